// File: rtl/trace_mgmt_pkg.sv
// Shared constants and helpers for the trace management bit deserializer.
// Optional parity support is selected by the TRACE_DESER_PARITY_EN macro.
package trace_mgmt_pkg;

    localparam int WORD_W_DEF   = 32;
    localparam int WORDS_OUT_W  = 16;
    localparam int PARITY_VEC_W = 64;

`ifdef TRACE_DESER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Even parity: returns the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [PARITY_VEC_W-1:0] vec);
        return ^vec;
    endfunction

endpackage

// File: rtl/trace_mgmt_out_reg.sv
// One-entry registered Avalon-ST source stage: loads a word, holds it while
// stalled, and drops valid once the consumer takes it.
module trace_mgmt_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              take
);

    assign take = out_valid && out_ready;

    // The producer only asserts load when the slot is empty or being taken,
    // so out_data never changes under a stalled valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/trace_mgmt_bit_deserializer.sv
// Packs a 1-bit Avalon-ST stream into WORD_W-bit words for the register decoder.
// Define TRACE_DESER_PARITY_EN to expect a trailing even-parity bit per word.
module trace_mgmt_bit_deserializer
    import trace_mgmt_pkg::*;
#(
    parameter int WORD_W    = WORD_W_DEF,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    output logic                   in_ready,
    input  logic                   in_valid,
    input  logic                   in_data,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [WORD_W-1:0]      out_data,
    output logic [WORDS_OUT_W-1:0] words_out
`ifdef TRACE_DESER_PARITY_EN
    ,
    output logic                   out_error
`endif
);

    localparam int LAST  = WORD_W - 1 + PARITY_BITS;
    localparam int CNT_W = $clog2(LAST + 1);
    localparam int PAY_W = WORD_W + PARITY_BITS;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST);

    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_next;
    logic              at_last;
    logic              accept;
    logic              load;
    logic              take;
    logic [PAY_W-1:0]  load_word;
    logic [PAY_W-1:0]  out_word;

    assign at_last  = (cnt == CNT_LAST);
    // Only the completing bit needs a free output slot; earlier bits always land.
    assign in_ready = !flush && !(at_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && at_last;

    // NOTE: every signal assigned in always_comb gets a value on all paths,
    // otherwise synthesis infers a latch.
    always_comb begin
        shreg_next = shreg;
        if (LSB_FIRST) begin
            shreg_next = {in_data, shreg[WORD_W-1:1]};
        end else begin
            shreg_next = {shreg[WORD_W-2:0], in_data};
        end
    end

`ifdef TRACE_DESER_PARITY_EN
    // The completing beat is the parity bit; data bits are already in shreg.
    assign load_word = {even_parity(PARITY_VEC_W'(shreg)) ^ in_data, shreg};
    assign out_error = out_word[WORD_W];
`else
    assign load_word = shreg_next;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (flush || load) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (accept) begin
            cnt   <= cnt + 1'b1;
            shreg <= shreg_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            words_out <= '0;
        end else if (take) begin
            words_out <= words_out + 1'b1;
        end
    end

    trace_mgmt_out_reg #(
        .DATA_W(PAY_W)
    ) u_out_reg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_data(load_word),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_word),
        .take     (take)
    );

    assign out_data = out_word[WORD_W-1:0];

endmodule

// File: tb/tb_trace_mgmt_bit_deserializer.sv
// Directed bench for trace_mgmt_bit_deserializer (WORD_W=8, both bit orders).
// Also covers the TRACE_DESER_PARITY_EN build when that macro is defined.
module tb_trace_mgmt_bit_deserializer;
    import trace_mgmt_pkg::*;

    localparam int W     = 8;
    localparam int NBITS = W + PARITY_BITS;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_data;
    logic        out_ready;
    logic        in_ready,  in_ready_m;
    logic        out_valid, out_valid_m;
    logic [W-1:0] out_data, out_data_m;
    logic [15:0] words_out, words_out_m;
`ifdef TRACE_DESER_PARITY_EN
    logic        out_error, out_error_m;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trace_mgmt_bit_deserializer #(.WORD_W(W), .LSB_FIRST(1'b1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_ready (in_ready),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .words_out(words_out)
`ifdef TRACE_DESER_PARITY_EN
        ,
        .out_error(out_error)
`endif
    );

    trace_mgmt_bit_deserializer #(.WORD_W(W), .LSB_FIRST(1'b0)) dut_msb (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .in_ready (in_ready_m),
        .in_valid (in_valid),
        .in_data  (in_data),
        .out_ready(out_ready),
        .out_valid(out_valid_m),
        .out_data (out_data_m),
        .words_out(words_out_m)
`ifdef TRACE_DESER_PARITY_EN
        ,
        .out_error(out_error_m)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bit i of the serial stream for word w: data LSB first, then parity if enabled.
    function automatic logic stream_bit(input logic [7:0] w, input int i, input logic bad_par);
        if (i < W) return w[i];
        return (^w) ^ bad_par;
    endfunction

    // Offer one bit at a falling edge; the next rising edge accepts it.
    task automatic drive_bit(input logic b, input string tag);
        in_valid = 1'b1;
        in_data  = b;
        #1;
        check(tag, in_ready, 1'b1);
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input logic bad_par, input string tag);
        for (int i = 0; i < NBITS; i++) drive_bit(stream_bit(w, i, bad_par), tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data",  out_data,  8'h00);
        check("rst_words", words_out, 16'h0);
`ifdef TRACE_DESER_PARITY_EN
        check("rst_error", out_error, 1'b0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        // Single word, both bit orders
        send_word(8'h0D, 1'b0, "rdy_w1");
        in_valid = 1'b0;
        check("w1_valid",      out_valid,  1'b1);
        check("w1_data",       out_data,   8'h0D);
        check("w1_msb_data",   out_data_m, 8'hB0);
        check("w1_words_pre",  words_out,  16'd0);
`ifdef TRACE_DESER_PARITY_EN
        check("w1_error",      out_error,  1'b0);
`endif
        @(negedge clk);
        check("w1_taken_valid", out_valid, 1'b0);
        check("w1_words",       words_out, 16'd1);

        // Back-to-back words with no bubble
        send_word(8'h0D, 1'b0, "rdy_b2b");
        check("b2b_first_valid", out_valid, 1'b1);
        check("b2b_first_data",  out_data,  8'h0D);
        send_word(8'hFF, 1'b0, "rdy_b2b");
        in_valid = 1'b0;
        check("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second_data",  out_data,  8'hFF);
        check("b2b_words_mid",    words_out, 16'd2);
        @(negedge clk);
        check("b2b_words", words_out, 16'd3);
        check("b2b_idle",  out_valid, 1'b0);

        // Backpressure: stall only on the completing bit
        send_word(8'h3C, 1'b0, "rdy_bp_w1");
        out_ready = 1'b0;
        for (int i = 0; i < NBITS - 1; i++) drive_bit(stream_bit(8'hC3, i, 1'b0), "rdy_bp_partial");
        in_valid = 1'b1;
        in_data  = stream_bit(8'hC3, NBITS - 1, 1'b0);
        #1;
        check("bp_stall_ready", in_ready,  1'b0);
        check("bp_hold_valid",  out_valid, 1'b1);
        check("bp_hold_data",   out_data,  8'h3C);
        check("bp_hold_words",  words_out, 16'd3);
        @(negedge clk);
        #1;
        check("bp_stall_ready2", in_ready, 1'b0);
        check("bp_hold_data2",   out_data, 8'h3C);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_w2_valid", out_valid, 1'b1);
        check("bp_w2_data",  out_data,  8'hC3);
        check("bp_w2_words", words_out, 16'd4);
        @(negedge clk);
        check("bp_words", words_out, 16'd5);
        check("bp_idle",  out_valid, 1'b0);

        // Flush discards a partial word
        for (int i = 0; i < 5; i++) drive_bit(1'b1, "rdy_pre_flush");
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 1'b1;
        #1;
        check("flush_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        send_word(8'h5A, 1'b0, "rdy_post_flush");
        in_valid = 1'b0;
        check("flush_valid",    out_valid,  1'b1);
        check("flush_data",     out_data,   8'h5A);
        check("flush_msb_data", out_data_m, 8'h5A);
        @(negedge clk);
        check("flush_words", words_out, 16'd6);

`ifdef TRACE_DESER_PARITY_EN
        send_word(8'h0D, 1'b0, "rdy_par_ok");
        in_valid = 1'b0;
        check("par_ok_data",  out_data,  8'h0D);
        check("par_ok_error", out_error, 1'b0);
        @(negedge clk);
        send_word(8'h0D, 1'b1, "rdy_par_bad");
        in_valid = 1'b0;
        check("par_bad_data",  out_data,  8'h0D);
        check("par_bad_error", out_error, 1'b1);
        @(negedge clk);
`endif

        // words_out wrap
        force dut.words_out = 16'hFFFF;
        #1;
        release dut.words_out;
        #1;
        check("wrap_preset", words_out, 16'hFFFF);
        @(negedge clk);
        send_word(8'h12, 1'b0, "rdy_wrap");
        in_valid = 1'b0;
        check("wrap_data", out_data, 8'h12);
        @(negedge clk);
        check("wrap_words", words_out, 16'h0000);

        // Asynchronous reset with a pending word and a partial word
        send_word(8'h77, 1'b0, "rdy_rst_w1");
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        send_word(8'h66, 1'b0, "rdy_rst_w2");
        for (int i = 0; i < 3; i++) drive_bit(1'b1, "rdy_rst_partial");
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1'b1);
        check("pre_rst_words", words_out, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async_valid", out_valid, 1'b0);
        check("rst_async_words", words_out, 16'd0);
        check("rst_async_data",  out_data,  8'h00);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        send_word(8'h81, 1'b0, "rdy_post_rst");
        in_valid = 1'b0;
        check("post_rst_data",     out_data,   8'h81);
        check("post_rst_msb_data", out_data_m, 8'h81);
        @(negedge clk);
        check("post_rst_words", words_out, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trace_mgmt_bit_deserializer.md
Name: trace_mgmt_bit_deserializer

Overview:
Downstream neighbour of the trace-system management demux port adapter. It consumes the adapter's 1-bit Avalon-ST output stream and packs successive bits into WORD_W-bit words. Each word is presented on a registered Avalon-ST source with full valid/ready backpressure. It feeds the management register decoder, and it sustains one bit per cycle with no bubbles while the sink is ready.

Parameters:
WORD_W, 32, output word width in bits; legal values are 2..64.
LSB_FIRST, 1, 1: the first received bit becomes word bit 0; 0: the first received bit becomes word bit WORD_W-1.

Ports:
clk  input  1  single clock for all logic
reset_n  input  1  reset, asynchronous assert, active-low
flush  input  1  synchronous discard of any partially assembled word
in_ready  output  1  sink ready for the 1-bit stream
in_valid  input  1  sink valid
in_data  input  1  serial data bit
out_ready  input  1  source ready from the downstream consumer
out_valid  output  1  source valid (registered)
out_data  output  WORD_W  assembled word (registered)
words_out  output  16  count of words accepted downstream (registered)
out_error  output  1  parity error flag travelling with the word; present only with TRACE_DESER_PARITY_EN

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - out_valid=0, out_data=0, words_out=0, out_error=0.
  - Internal shift register is 0 and the bit counter cnt is 0.
  - in_ready is combinational and may be 1 while reset_n is low; no beats are accepted during reset.
- Accepting a beat:
  - A beat is accepted when in_valid && in_ready.
  - cnt counts accepted bits from 0 to LAST. LAST=WORD_W-1, or WORD_W when parity is enabled.
  - A data bit is shifted into the position selected by LSB_FIRST.
- Word completion:
  - When the beat that completes the word is accepted, the next edge loads out_data with the completed word, sets out_valid=1 and sets cnt=0.
  - Latency is one cycle from the last-bit acceptance edge to out_valid high.
- Output register:
  - out_valid clears on an edge with out_ready=1, unless a new word loads on that same edge, in which case it stays 1.
  - out_data and out_valid stay stable while out_valid && !out_ready (Avalon-ST source rule).
- in_ready is 0 in exactly two cases; otherwise it is 1:
  - flush=1;
  - cnt==LAST && out_valid && !out_ready, i.e. the completing bit would have nowhere to go.
- A non-completing bit is always accepted, even while the output register is stalled. This gives full throughput.
- Simultaneous events:
  - If the completing bit and out_ready arrive together while the output holds a word, the old word is taken and the new word loads on the same edge.
  - words_out increments on that edge.
- flush:
  - flush=1 clears cnt and the shift register on the next edge.
  - The output register is untouched: a pending word stays valid until taken.
  - Beats offered while flush=1 are not accepted (in_ready=0).
- words_out:
  - Increments by 1 on every edge with out_valid && out_ready.
  - Wraps 0xFFFF -> 0x0000.
- Reset mid-word discards the partial word and any pending output word.
- cnt width is $clog2(LAST+1). cnt never exceeds LAST.

Optional Feature:
Macro: TRACE_DESER_PARITY_EN.
- Defined:
  - Each word is followed by one extra serial bit carrying even parity over the WORD_W data bits.
  - The parity bit is not stored in out_data.
  - out_error is loaded with the word, =1 on parity mismatch, and has the same hold and stall rules as out_data.
  - LAST=WORD_W.
- Undefined:
  - No parity bit is expected and the out_error port does not exist.
  - LAST=WORD_W-1.

Decomposition:
- Shared package trace_mgmt_pkg holds:
  - WORD_W default constant;
  - the words_out width constant (16);
  - a function for even parity over a vector.
- One natural sub-module, trace_mgmt_out_reg: a one-entry registered Avalon-ST output stage with load/hold/take logic.
- The bit counter, shift register and word counter stay in the top level.

Test Plan:
- WORD_W=8, LSB_FIRST=1, out_ready=1, stream bits 1,0,1,1,0,0,0,0 on consecutive cycles -> out_valid high one cycle after the 8th bit, out_data=0x0D, words_out=1.
- Same bits with LSB_FIRST=0 -> out_data=0xB0.
- Back-to-back words:
  - WORD_W=8, send 0x0D then 0xFF continuously with out_ready=1;
  - expect in_ready to stay 1 throughout, out_valid on two consecutive word boundaries, and words_out=2.
- Backpressure:
  - out_ready=0 after the first word; send 8 more bits;
  - expect the first 7 to be accepted, in_ready=0 on the 8th, and out_data held at the first word;
  - raise out_ready: the 8th bit is accepted, the second word loads on the same edge, and there is no loss or duplication.
- Flush:
  - After 5 bits, pulse flush one cycle, then send the 8 bits of 0x5A;
  - expect out_data=0x5A, with the 5 stale bits discarded and in_ready=0 during the flush cycle;
  - assert reset_n low mid-word: out_valid=0, words_out=0 immediately (asynchronous).
- TRACE_DESER_PARITY_EN, WORD_W=8:
  - Send 0x0D then parity 1 -> out_data=0x0D, out_error=0;
  - send 0x0D then parity 0 -> out_error=1;
  - force words_out to 0xFFFF, then take one word -> words_out=0x0000.
